// File: rtl/if_stage_prefetch.sv
// if_stage_prefetch: instruction-fetch stage with a credit-based prefetch FIFO.
// Issues sequential fetch requests, buffers returned words and presents the
// oldest one to ID. A branch redirect flushes the buffer and arranges for every
// response still in flight to be discarded when it arrives.
module if_stage_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              if_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction
);

    localparam int                CW      = $clog2(DEPTH) + 1;
    localparam int                PW      = $clog2(DEPTH);
    localparam logic [CW:0]       DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);

    // Next address to request, and fetch address of the next non-stale response.
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;

    // Occupancy bookkeeping: buffered words, requests in flight, stale responses.
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [CW:0]       credits_used;
    logic              accept;
    logic              rsp_fire;
    logic              push;
    logic              pop;
    logic [CW-1:0]     outstanding_next;
    logic [CW-1:0]     count_next;

    // Credit check, handshakes and FIFO push/pop decisions for this cycle.
    always_comb begin
        credits_used     = {1'b0, count} + {1'b0, outstanding};
        mem_req_valid    = !rst && (credits_used < DEPTH_L);
        mem_req_addr     = fetch_pc;
        accept           = mem_req_valid && mem_req_ready;
        rsp_fire         = mem_rsp_valid && !rst && (outstanding != '0);
        push             = rsp_fire && !branch_taken && (drop == '0);
        if_valid         = !rst && (count != '0);
        pop              = if_valid && !freeze && !branch_taken;
        outstanding_next = outstanding + {{(CW-1){1'b0}}, accept}
                                       - {{(CW-1){1'b0}}, rsp_fire};
        count_next       = count + {{(CW-1){1'b0}}, push}
                                 - {{(CW-1){1'b0}}, pop};
        pc               = if_valid ? pc_mem[rd_ptr]   : '0;
        instruction      = if_valid ? data_mem[rd_ptr] : '0;
    end

    // Control state: fetch pointer, counters, FIFO pointers, branch flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (branch_taken) begin
                fetch_pc <= branch_addr;
                rsp_pc   <= branch_addr;
                drop     <= outstanding_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + INC;
                end
                if (rsp_fire && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + INC;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count_next;
            end
        end
    end

    // FIFO storage: each entry holds the word and its fetch address + PC_INC.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc + INC;
        end
    end

    // Credit invariants: buffer plus flight never exceeds DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ({1'b0, count} + {1'b0, outstanding} <= DEPTH_L);
            assert (drop <= outstanding);
        end
    end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Testbench for if_stage_prefetch: a queued memory model with per-request
// latency, plus an address-stream reference for requests and the ID stream.
module tb_if_stage_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        if_valid;
    logic [31:0] pc;
    logic [31:0] instruction;

    if_stage_prefetch dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .if_valid      (if_valid),
        .pc            (pc),
        .instruction   (instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        memq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          ready_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          accepts = 0;
    int          pops = 0;
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_id = 32'h0;
    bit          expect_empty = 1'b0;
    logic        seen_valid;
    logic        seen_req_valid;
    logic [31:0] seen_req_addr;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, update the model.
    task automatic applyStimulus(input bit r, input bit f, input bit b, input logic [31:0] ba);
        int lat;
        int due;
        rst           = r;
        freeze        = f;
        branch_taken  = b;
        branch_addr   = ba;
        mem_req_ready = ($urandom_range(99) < ready_pct);
        if (!r && memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memfn(memq[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
        @(negedge clk);
        seen_valid     = if_valid;
        seen_req_valid = mem_req_valid;
        seen_req_addr  = mem_req_addr;
        if (r) begin
            checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
            checkOutput("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
            checkOutput("rst_pc", pc, 32'd0);
            checkOutput("rst_instr", instruction, 32'd0);
            memq.delete();
            exp_req      = 32'h0;
            exp_id       = 32'h0;
            last_due     = 0;
            expect_empty = 1'b0;
        end else begin
            if (expect_empty) checkOutput("branch_flush", {31'b0, if_valid}, 32'd0);
            if (if_valid) begin
                checkOutput("id_pc", pc, exp_id + 32'd4);
                checkOutput("id_instr", instruction, memfn(exp_id));
            end else begin
                checkOutput("empty_pc", pc, 32'd0);
                checkOutput("empty_instr", instruction, 32'd0);
            end
            if (mem_rsp_valid) void'(memq.pop_front());
            if (mem_req_valid) begin
                checkOutput("req_addr", mem_req_addr, exp_req);
                if (mem_req_ready) begin
                    lat = $urandom_range(lat_hi, lat_lo);
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    memq.push_back('{mem_req_addr, due});
                    exp_req = exp_req + 32'd4;
                    accepts++;
                end
            end
            checkOutput("occupancy", {31'b0, memq.size() <= DEPTH}, 32'd1);
            if (if_valid && !f && !b) begin
                exp_id = exp_id + 32'd4;
                pops++;
            end
            if (b) begin
                exp_req = ba;
                exp_id  = ba;
            end
            expect_empty = b;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        rst           = 1'b1;
        freeze        = 1'b0;
        branch_taken  = 1'b0;
        branch_addr   = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        @(posedge clk);
        #1;

        // Streaming: ready=1, L=1, first word presented on cycle 3.
        $display("[TB] streaming with L=1");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("stream_valid_c%0d", i), {31'b0, seen_valid}, (i >= 3) ? 32'd1 : 32'd0);
        end

        // Freeze: exactly DEPTH requests, then drain without a gap.
        $display("[TB] freeze credit exhaustion");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        accepts = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("freeze_reqs", 32'(accepts), 32'd4);
        checkOutput("freeze_req_valid", {31'b0, seen_req_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("drain_valid", {31'b0, seen_valid}, 32'd1);
        end

        // Branch latency with L=3 and three requests in flight.
        $display("[TB] branch latency L=3");
        lat_lo = 3;
        lat_hi = 3;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            n++;
            if (seen_valid) break;
        end
        checkOutput("branch_latency", 32'(n), 32'd5);

        // Branch under freeze while a response arrives in the same cycle.
        $display("[TB] branch with freeze and response");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("freeze_branch_flush", {31'b0, seen_valid}, 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Address wrap, then reset in the middle of a burst.
        $display("[TB] address wrap and mid-burst reset");
        lat_lo = 1;
        lat_hi = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_mid_if_valid", {31'b0, seen_valid}, 32'd0);
        checkOutput("rst_mid_req_valid", {31'b0, seen_req_valid}, 32'd1);
        checkOutput("rst_mid_req_addr", seen_req_addr, 32'h0);

        // Randomised traffic: random ready, latency, freeze and branches.
        $display("[TB] random traffic");
        ready_pct = 50;
        lat_lo    = 1;
        lat_hi    = 4;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b0, $urandom_range(99) < 30, $urandom_range(99) < 4,
                          $urandom & 32'hFFFF_FFFC);
        end
        checkOutput("random_progress", {31'b0, pops > 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
